// File: rtl/cla_pkg.sv
// Shared types and look-ahead carry helpers for the pipelined CLA adder.
// Optional feature macro used by the top: CLA_SUB_EN (adds Sub/Ovf).
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Full look-ahead: every carry is a flat sum-of-products of g, p and c_in.
  function automatic logic [GROUP_W:0] cla_carries(
    input logic [GROUP_W-1:0] g,
    input logic [GROUP_W-1:0] p,
    input logic               c_in
  );
    logic [GROUP_W:0] c;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);
    return c;
  endfunction

  function automatic gp_t cla_group_gp(
    input logic [GROUP_W-1:0] g,
    input logic [GROUP_W-1:0] p
  );
    gp_t gp;
    gp.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp.p = &p;
    return gp;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit carry-look-ahead group: sum, carry out and group generate/propagate.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] i_a,
  input  logic [GROUP_W-1:0] i_b,
  input  logic               i_c,
  output logic [GROUP_W-1:0] o_s,
  output logic               o_co,
  output gp_t                o_gp
);

  logic [GROUP_W-1:0] w_g;
  logic [GROUP_W-1:0] w_p;
  logic [GROUP_W:0]   w_c;

  assign w_g  = i_a & i_b;
  assign w_p  = i_a ^ i_b;
  assign w_c  = cla_carries(w_g, w_p, i_c);
  assign o_s  = w_p ^ w_c[GROUP_W-1:0];
  assign o_co = w_c[GROUP_W];
  assign o_gp = cla_group_gp(w_g, w_p);

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-look-ahead adder with elastic valid/ready on both sides.
// Define CLA_SUB_EN to add the Sub input and signed-overflow Ovf output.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef CLA_SUB_EN
  input  logic             Sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
`ifdef CLA_SUB_EN
  output logic             Ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int GROUPS = WIDTH / GROUP_W;
  localparam int GPS    = GROUPS / STAGES;
  localparam int SW     = GPS * GROUP_W;

  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;

`ifdef CLA_SUB_EN
  // Subtraction is folded in at the entry: the pipeline only ever adds.
  assign w_b_in = Sub ? ~B : B;
  assign w_c_in = Sub ? 1'b1 : Cin;
`else
  assign w_b_in = B;
  assign w_c_in = Cin;
`endif

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [STAGES-1:0] r_carry;

  logic [STAGES-1:0] w_acc;
  logic [STAGES-1:0] w_src_v;
  logic [STAGES-1:0] w_nxt_c;
  logic [WIDTH-1:0]  w_src_a   [STAGES];
  logic [WIDTH-1:0]  w_src_b   [STAGES];
  logic [WIDTH-1:0]  w_nxt_sum [STAGES];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [WIDTH-1:0] w_src_sum;
    logic [WIDTH-1:0] w_sum_mix;
    logic [SW-1:0]    w_grp_sum;
    logic [GPS:0]     w_c;
    gp_t  [GPS-1:0]   w_gp;
    logic             w_unused_gp;

    // acc[s] is the unrolled accept chain: stage s stalls only when it and
    // every stage after it hold data and the sink is not taking any.
    assign w_acc[s] = out_ready | ~(&r_valid[STAGES-1:s]);

    if (s == 0) begin : g_src_in
      assign w_src_v[s] = in_valid;
      assign w_src_a[s] = A;
      assign w_src_b[s] = w_b_in;
      assign w_src_sum  = '0;
      assign w_c[0]     = w_c_in;
    end else begin : g_src_reg
      assign w_src_v[s] = r_valid[s-1];
      assign w_src_a[s] = r_a[s-1];
      assign w_src_b[s] = r_b[s-1];
      assign w_src_sum  = r_sum[s-1];
      assign w_c[0]     = r_carry[s-1];
    end

    for (genvar g = 0; g < GPS; g++) begin : g_grp
      localparam int LSB = (s * GPS + g) * GROUP_W;
      cla_group4 u_grp (
        .i_a  (w_src_a[s][LSB +: GROUP_W]),
        .i_b  (w_src_b[s][LSB +: GROUP_W]),
        .i_c  (w_c[g]),
        .o_s  (w_grp_sum[g*GROUP_W +: GROUP_W]),
        .o_co (w_c[g+1]),
        .o_gp (w_gp[g])
      );
    end

    // Groups inside a stage ripple through o_co; G/P stays available for a
    // second-level look-ahead if a stage ever grows wide enough to need it.
    assign w_unused_gp = ^w_gp;

    always_comb begin
      // NOTE: default first so the partial overwrite below cannot infer a latch.
      w_sum_mix = w_src_sum;
      w_sum_mix[s*SW +: SW] = w_grp_sum;
    end

    assign w_nxt_sum[s] = w_sum_mix;
    assign w_nxt_c[s]   = w_c[GPS];
  end

  assign in_ready = w_acc[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data registers are reset along with the valids so Sum/Cout read 0.
      r_valid <= '0;
      r_carry <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_a[s]   <= '0;
        r_b[s]   <= '0;
        r_sum[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (w_acc[s]) begin
          // NOTE: non-blocking so stage s+1 takes stage s's pre-edge contents.
          r_valid[s] <= w_src_v[s];
          r_a[s]     <= w_src_a[s];
          r_b[s]     <= w_src_b[s];
          r_sum[s]   <= w_nxt_sum[s];
          r_carry[s] <= w_nxt_c[s];
        end
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign Sum       = r_sum[STAGES-1];
  assign Cout      = r_carry[STAGES-1];

`ifdef CLA_SUB_EN
  logic w_c_msb;
  logic w_ovf_nxt;
  logic r_ovf;

  // Carry into the MSB recovered from a ^ b ^ sum at that bit.
  assign w_c_msb   = w_src_a[STAGES-1][WIDTH-1] ^ w_src_b[STAGES-1][WIDTH-1]
                   ^ w_nxt_sum[STAGES-1][WIDTH-1];
  assign w_ovf_nxt = w_c_msb ^ w_nxt_c[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_acc[STAGES-1]) begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign Ovf = r_ovf;
`endif

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe: random and directed traffic scored
// against an arithmetic reference queue; CLA_SUB_EN adds subtract checks.
module tb_cla_adder_pipe;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] A, B;
  logic             Cin;
  logic             sub_i;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             ovf_o;
  logic             out_valid, out_ready;

  cla_adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
`ifdef CLA_SUB_EN
    .Sub       (sub_i),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Sum       (Sum),
    .Cout      (Cout),
`ifdef CLA_SUB_EN
    .Ovf       (ovf_o),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

`ifndef CLA_SUB_EN
  assign ovf_o = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH:0] val;
    logic           ovf;
    int             cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  int   n_in    = 0;
  int   cyc     = 0;
  bit   chk_lat = 0;
  bit   held    = 0;
  logic [WIDTH-1:0] held_sum;
  logic             held_cout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the accepted operands.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub, input int at_cyc);
    exp_t e;
    int   sa, sb, sr;
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      e.val = {1'b0, a} + {1'b0, ~b} + 17'd1;
      sr    = sa - sb;
    end else begin
      e.val = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      sr    = sa + sb + int'(cin);
    end
    e.ovf = (sr > 32767) || (sr < -32768);
    e.cyc = at_cyc;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 0;
    end else begin
      if (held) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_sum", {16'd0, Sum}, {16'd0, held_sum});
        check("hold_cout", {31'd0, Cout}, {31'd0, held_cout});
      end
      held = 0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_without_accept", {31'd0, out_valid}, 32'd0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          check("result", {15'd0, Cout, Sum}, {15'd0, e.val});
`ifdef CLA_SUB_EN
          check("ovf", {31'd0, ovf_o}, {31'd0, e.ovf});
`endif
          if (chk_lat) check("latency", cyc - e.cyc, STAGES);
          n_out++;
        end else begin
          check("stall_result", {15'd0, Cout, Sum}, {15'd0, exp_q[0].val});
          held      = 1;
          held_sum  = Sum;
          held_cout = Cout;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(A, B, Cin, sub_i, cyc));
        n_in++;
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub);
    A = a; B = b; Cin = cin; sub_i = sub; in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic load_random();
    A = WIDTH'($urandom); B = WIDTH'($urandom); Cin = 1'($urandom_range(0, 1));
  endtask

  logic [WIDTH-1:0] pat [5];
  int c0, base, n_acc, idx;
  bit acc;

  initial begin
    pat = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    rst = 1'b1; A = '0; B = '0; Cin = 1'b0; sub_i = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {16'd0, Sum}, 32'd0);
    check("rst_cout", {31'd0, Cout}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Corner-value sweep, back to back, latency checked per result.
    chk_lat = 1;
    c0 = cyc;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int k = 0; k < 2; k++)
          send(pat[i], pat[j], k[0], 1'b0);
    check("throughput_cycles", cyc - c0, 32'd50);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    drain();
    check("sweep_count", n_out, 32'd52);

`ifdef CLA_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      load_random();
      send(A, B, Cin, 1'($urandom_range(0, 1)));
    end
    drain();
`endif
    chk_lat = 0;

    // Backpressure: sink stalled, only STAGES transfers fit.
    base = n_out; n_acc = 0; idx = 0;
    out_ready = 1'b0;
    load_random(); in_valid = 1'b1;
    for (int cy = 0; cy < 40 && idx < 8; cy++) begin
      if (cy == 10) begin
        check("bp_accepts", n_acc, 32'd4);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        n_acc++; idx++;
        if (idx < 8) load_random(); else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    check("bp_emitted", n_out - base, 32'd8);

    // Bubbles with random sink backpressure; source holds until accepted.
    base = n_out; c0 = n_in; acc = 0;
    for (int cy = 0; cy < 300; cy++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && !acc) begin
        // hold current operands
      end else if (in_valid) begin
        in_valid = 1'b0;
      end else begin
        load_random(); in_valid = 1'b1;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    check("bubble_count", n_out - base, n_in - c0);

    // Reset with three transfers in flight.
    for (int k = 0; k < 3; k++) begin
      load_random();
      send(A, B, Cin, 1'b0);
    end
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sum", {16'd0, Sum}, 32'd0);
    check("midrst_cout", {31'd0, Cout}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    base = n_out;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_emit", n_out - base, 32'd0);
    check("midrst_idle_valid", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
